alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator-side driver for the 32-bit combinational ALU. It accepts operation commands over a valid/ready handshake and drives the ALU operand and opcode inputs. It captures the ALU result and flags into a held response. It also performs 32x32 multiply (low 32 bits) as a multi-cycle shift-and-add sequence that uses only the ALU's add and shift-left operations. It sits between the datapath control and the ALU.

Parameters:
WIDTH, 32, data width; only 32 is supported.
ALU_ADD, 3'b000, ALU opcode for add.
ALU_SHL, 3'b001, ALU opcode for shift-left.
ALU_AND, 3'b111, ALU opcode for bitwise AND.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  00 ADD, 01 SHL, 10 AND, 11 MUL
cmd_a  in  32  operand A
cmd_b  in  32  operand B (SHL: shift amount)
rsp_valid  out  1  response held
rsp_ready  in  1  consumer takes response
rsp_d  out  32  result
rsp_cout  out  1  carry flag
rsp_v  out  1  overflow flag
rsp_z  out  1  zero flag
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_op  out  3  ALU opcode
alu_d  in  32  ALU result
alu_cout  in  1  ALU carry
alu_v  in  1  ALU overflow (X for non-add)

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - rsp_valid=0; rsp_d=0; rsp_cout=0; rsp_v=0; rsp_z=0.
  - Internal acc, m, r are cleared.
  - Commands are ignored while reset is high.
  - Reset mid-operation abandons the operation; no response is produced.
- States: IDLE, EXEC, MADD, MSHL, RESP.
- cmd_ready = (state==IDLE). A command is accepted on clk when cmd_valid && cmd_ready.
- ALU drive outside EXEC/MADD/MSHL: alu_a=0, alu_b=0, alu_op=ALU_ADD.
- Command accepted with op ADD/SHL/AND:
  - Latch operands; go to EXEC.
  - EXEC: alu_a=A, alu_b=B, alu_op=mapped opcode.
  - At the end of EXEC: rsp_d<=alu_d; go to RESP.
  - For ADD only: rsp_cout<=alu_cout and rsp_v<=alu_v.
  - For SHL and AND: rsp_cout<=0 and rsp_v<=0.
  - rsp_valid is first high 2 cycles after the accept edge.
- SHL semantics are the ALU's: shift by B when B<31, else result = A. The sequencer does not clamp or modify B.
- MUL on accept: acc<=0, m<=cmd_a, r<=cmd_b. Next state:
  - RESP if cmd_b==0;
  - else MADD if cmd_b[0];
  - else MSHL.
- MADD:
  - Drive alu_a=acc, alu_b=m, alu_op=ALU_ADD; acc<=alu_d.
  - Next: RESP if r[31:1]==0, else MSHL.
- MSHL:
  - Drive alu_a=m, alu_b=1, alu_op=ALU_SHL; m<=alu_d; r<=r>>1.
  - Next: MADD if r[1], else MSHL. r>>1 is nonzero by construction.
- MUL arithmetic:
  - All arithmetic wraps modulo 2^32; rsp_d = low 32 bits of A*B (unsigned).
  - rsp_cout=0 and rsp_v=0 for MUL.
- MUL busy cycles = popcount(B) + msb_index(B), or 0 when B==0. rsp_valid is high the cycle after the last busy cycle.
- rsp_z = (rsp_d==0) for every op, registered together with rsp_d.
- RESP handshake:
  - rsp_valid=1; all rsp_* outputs are stable until rsp_valid && rsp_ready.
  - Then go to IDLE; rsp_valid=0 and cmd_ready=1 on the next cycle.
  - There is no same-cycle response-to-command turnaround.
- rsp_* outputs keep their last values while IDLE. Only rsp_valid qualifies them.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001, rsp_ready=1 -> rsp_d=0x80000000, v=1, cout=0, z=0. rsp_valid 2 cycles after the accept edge; cmd_ready low during EXEC/RESP.
- ADD a=0x80000000, b=0x80000000 -> rsp_d=0, cout=1, v=1, z=1.
- SHL a=3, b=4 -> rsp_d=0x30, cout=0, v=0. SHL a=0x5, b=31 -> rsp_d=0x5. AND a=0xF0F0, b=0xFF00 -> rsp_d=0xF000.
- MUL a=7, b=5:
  - alu_op sequence 000, 001, 001, 000 (4 busy cycles) -> rsp_d=35, z=0.
  - MUL a=9, b=0 -> no ALU cycles, rsp_d=0, z=1, rsp_valid 1 cycle after accept.
- MUL a=0x00010000, b=0x00010000 -> 17 busy cycles, rsp_d=0 (wrap), z=1, cout=0, v=0. MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> rsp_d=0x00000001.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0, no second accept.
  - Assert reset during the MSHL of a MUL -> IDLE next cycle, rsp_valid=0, no response issued.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: drives a combinational ALU for add/shl/and
// and runs 32x32 low-word multiply as a shift-and-add sequence.
module alu_cmd_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SHL = 3'b001,
  parameter logic [2:0] ALU_AND = 3'b111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_d,
  output logic             rsp_cout,
  output logic             rsp_v,
  output logic             rsp_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_cout,
  input  logic             alu_v
);

  typedef enum logic [2:0] {
    IDLE, EXEC, MADD, MSHL, RESP
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  state_t           state;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] r;

  assign cmd_ready = (state == IDLE);

  // ALU operand/opcode steering, idle drive is a harmless add of zeros
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    unique case (state)
      EXEC: begin
        alu_a = opa;
        alu_b = opb;
        unique case (1'b1)
          (op == OP_SHL): alu_op = ALU_SHL;
          (op == OP_AND): alu_op = ALU_AND;
          default:        alu_op = ALU_ADD;
        endcase
      end
      MADD: begin
        alu_a  = acc;
        alu_b  = m;
        alu_op = ALU_ADD;
      end
      MSHL: begin
        alu_a  = m;
        alu_b  = WIDTH'(1);
        alu_op = ALU_SHL;
      end
      default: ;
    endcase
  end

  // Command FSM, multiply datapath and held response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_ADD;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      m         <= '0;
      r         <= '0;
      rsp_valid <= 1'b0;
      rsp_d     <= '0;
      rsp_cout  <= 1'b0;
      rsp_v     <= 1'b0;
      rsp_z     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op  <= cmd_op;
            opa <= cmd_a;
            opb <= cmd_b;
            if (cmd_op == OP_MUL) begin
              acc <= '0;
              m   <= cmd_a;
              r   <= cmd_b;
              if (cmd_b == '0) begin
                rsp_d     <= '0;
                rsp_z     <= 1'b1;
                rsp_cout  <= 1'b0;
                rsp_v     <= 1'b0;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end else if (cmd_b[0]) begin
                state <= MADD;
              end else begin
                state <= MSHL;
              end
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_d     <= alu_d;
          rsp_z     <= (alu_d == '0);
          rsp_cout  <= (op == OP_ADD) ? alu_cout : 1'b0;
          rsp_v     <= (op == OP_ADD) ? alu_v : 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        MADD: begin
          acc <= alu_d;
          if (r[WIDTH-1:1] == '0) begin
            rsp_d     <= alu_d;
            rsp_z     <= (alu_d == '0);
            rsp_cout  <= 1'b0;
            rsp_v     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            state <= MSHL;
          end
        end
        MSHL: begin
          m     <= alu_d;
          r     <= r >> 1;
          state <= r[1] ? MADD : MSHL;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, response scoreboard,
// latency / opcode-sequence checks, backpressure and reset abort.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_d;
  logic        rsp_cout;
  logic        rsp_v;
  logic        rsp_z;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_d;
  logic        alu_cout;
  logic        alu_v;

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        v;
    logic        z;
  } rsp_t;

  rsp_t        q[$];
  int          nchk = 0;
  int          nerr = 0;
  int          nops;
  logic [47:0] seq;

  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_d(rsp_d), .rsp_cout(rsp_cout),
    .rsp_v(rsp_v), .rsp_z(rsp_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_d(alu_d), .alu_cout(alu_cout), .alu_v(alu_v)
  );

  always #5 clk = ~clk;

  // behavioural ALU; flags are junk (1) for non-add ops
  always_comb begin
    alu_d    = '0;
    alu_cout = 1'b1;
    alu_v    = 1'b1;
    case (alu_op)
      3'b000: begin
        {alu_cout, alu_d} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[31] == alu_b[31]) && (alu_d[31] != alu_a[31]);
      end
      3'b001: alu_d = (alu_b < 31) ? (alu_a << alu_b[4:0]) : alu_a;
      3'b111: alu_d = alu_a & alu_b;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t model(input logic [1:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    rsp_t        e;
    logic [32:0] s;
    e = '0;
    case (op)
      2'b00: begin
        s   = {1'b0, a} + {1'b0, b};
        e.d = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      2'b01: e.d = (b < 31) ? (a << b[4:0]) : a;
      2'b10: e.d = a & b;
      default: e.d = a * b;
    endcase
    e.z = (e.d == 0);
    return e;
  endfunction

  function automatic int lat_of(input logic [1:0] op,
                               input logic [31:0] b);
    int pc;
    int msb;
    if (op != 2'b11) return 2;
    if (b == 0) return 1;
    pc  = 0;
    msb = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        pc++;
        msb = i;
      end
    end
    return 1 + pc + msb;
  endfunction

  // scoreboard: pop and compare whenever a response is taken
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("unexp_rsp", {63'd0, rsp_valid}, 64'd0);
      end else begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_d", {32'd0, rsp_d}, {32'd0, e.d});
        chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, e.c});
        chk("rsp_v", {63'd0, rsp_v}, {63'd0, e.v});
        chk("rsp_z", {63'd0, rsp_z}, {63'd0, e.z});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    @(negedge clk);
    chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    q.push_back(model(op, a, b));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    nops = 0;
    seq  = '0;
    n    = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rsp_valid) begin
        chk("busy_ready", {63'd0, cmd_ready}, 64'd0);
        seq = {seq[44:0], alu_op};
        nops++;
      end
    end while (!rsp_valid && n < 100);
    chk("latency", 64'(n), 64'(lat_of(op, b)));
    chk("resp_ready", {63'd0, cmd_ready}, 64'd0);
    if (rsp_ready) begin
      @(negedge clk);
      chk("post_valid", {63'd0, rsp_valid}, 64'd0);
      chk("post_ready", {63'd0, cmd_ready}, 64'd1);
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_d", {32'd0, rsp_d}, 64'd0);
    chk("rst_z", {63'd0, rsp_z}, 64'd0);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_aluop", {61'd0, alu_op}, 64'd0);
    chk("rst_alua", {32'd0, alu_a}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    issue(2'b00, 32'h7FFF_FFFF, 32'h1);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    issue(2'b01, 32'd3, 32'd4);
    issue(2'b01, 32'd5, 32'd31);
    issue(2'b10, 32'hF0F0, 32'hFF00);

    issue(2'b11, 32'd7, 32'd5);
    chk("mul75_nops", 64'(nops), 64'd4);
    chk("mul75_seq", {52'd0, seq[11:0]}, {52'd0, 12'b000_001_001_000});
    issue(2'b11, 32'd9, 32'd0);
    chk("mul90_nops", 64'(nops), 64'd0);
    issue(2'b11, 32'h0001_0000, 32'h0001_0000);
    chk("mulwrap_nops", 64'(nops), 64'd17);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 1023);
      issue(2'(i % 4), ra, (i % 4 == 3) ? rb : $urandom);
    end

    // backpressure: response must hold while a new command waits
    rsp_ready = 1'b0;
    issue(2'b00, 32'd1, 32'd2);
    held      = rsp_d;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_a     = 32'hDEAD;
    cmd_b     = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_d", {32'd0, rsp_d}, {32'd0, held});
      chk("bp_ready", {63'd0, cmd_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_post_valid", {63'd0, rsp_valid}, 64'd0);
    chk("bp_post_ready", {63'd0, cmd_ready}, 64'd1);

    // reset in the middle of a multiply (b=4: MSHL, MSHL, MADD)
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_a     = 32'd3;
    cmd_b     = 32'd4;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_shl", {61'd0, alu_op}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_ready", {63'd0, cmd_ready}, 64'd1);
    chk("abort_d", {32'd0, rsp_d}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_quiet", {63'd0, rsp_valid}, 64'd0);
    end

    issue(2'b11, 32'd6, 32'd7);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
